// File: rtl/uart_pkg.sv
// uart_pkg: types, default constants and helper shared by the UART receive path.
//   uart_rx_state_t : receiver FSM state encoding
//   CLK_FREQ_HZ     : default system clock frequency (Hz)
//   UART_BAUD       : default line baud rate
//   calc_div()      : clocks per oversample tick, integer-truncated
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_t;

  localparam int CLK_FREQ_HZ = 100_000_000;
  localparam int UART_BAUD   = 9600;

  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    return clk_freq / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider producing one-cycle oversample ticks.
//   clk  : system clock
//   rst  : asynchronous, active-high reset (count 0, tick 0)
//   clr  : synchronous restart of the count, aligns tick phase to an event
//   tick : high for one clk every DIV clks, in the cycle the count is DIV-1
// DIV must be at least 2.
module uart_baud_tick #(
  parameter int DIV = 651
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST     = CW'(DIV - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(DIV - 2);

  logic [CW-1:0] count;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      if (clr || count == LAST) count <= '0;
      else                      count <= count + 1'b1;
      // Registered one cycle early so tick is high exactly while count == LAST.
      tick <= !clr && (count == PRE_LAST);
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 (configurable width) UART receiver, LSB first, oversampled.
//   clk       : system clock
//   rst       : asynchronous, active-high reset
//   rx        : serial line, idle high, asynchronous to clk
//   rx_data   : last correctly framed word, stable until the next good frame
//   rx_valid  : one-cycle pulse, rx_data updates in the same cycle
//   frame_err : one-cycle pulse when the stop bit samples low
//   busy      : high whenever the FSM is not idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = CLK_FREQ_HZ,
  parameter int BAUD       = UART_BAUD,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int DIV  = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int SC_W = $clog2(OVERSAMPLE);
  localparam int BC_W = $clog2(DATA_BITS + 1);

  localparam logic [SC_W-1:0] SC_MID  = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SC_W-1:0] SC_END  = SC_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

  uart_rx_state_t       state;
  logic [SC_W-1:0]      sc;
  logic [BC_W-1:0]      bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 rx_meta;
  logic                 rx_s;
  logic                 tick;
  logic                 tick_clr;

  // Two-flop synchroniser; resets to the idle level so reset release never
  // looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Restart the divider on the IDLE->START transition so all later samples
  // are phase-aligned to the detected start edge.
  assign tick_clr = (state == IDLE) && !rx_s;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sc        <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            sc    <= '0;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (tick) begin
            if (sc == SC_MID) begin
              sc <= '0;
              if (!rx_s) begin
                state   <= DATA;
                bit_cnt <= '0;
              end else begin
                // Line went back high before mid start bit: treat as glitch.
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              sc <= sc + 1'b1;
            end
          end
        end

        DATA: begin
          if (tick) begin
            if (sc == SC_END) begin
              // LSB arrives first, so bits enter at the MSB and shift down.
              shift   <= {rx_s, shift[DATA_BITS-1:1]};
              sc      <= '0;
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == BC_LAST) state <= STOP;
            end else begin
              sc <= sc + 1'b1;
            end
          end
        end

        STOP: begin
          if (tick) begin
            if (sc == SC_END) begin
              if (rx_s) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
              // Leaving at mid stop bit leaves half a bit to catch the next
              // start edge at full back-to-back rate.
              state <= IDLE;
              sc    <= '0;
              busy  <= 1'b0;
            end else begin
              sc <= sc + 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx.
// CLK_FREQ=1_600_000, BAUD=10_000, OVERSAMPLE=16 -> DIV=10, 160 clks per bit.
module tb_uart_rx;

  localparam int BIT_CLKS = 160;
  localparam int BIT_FAST = 155;  // transmitter bit period -3 %
  localparam int BIT_SLOW = 165;  // transmitter bit period +3 %

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor state.
  int         cyc          = 0;
  int         valid_cnt    = 0;
  int         ferr_cnt     = 0;
  int         both_cnt     = 0;
  int         last_valid_cyc = 0;
  logic [7:0] data_q[$];

  uart_rx #(
    .CLK_FREQ   (1_600_000),
    .BAUD       (10_000),
    .OVERSAMPLE (16),
    .DATA_BITS  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt++;
      last_valid_cyc = cyc;
      data_q.push_back(rx_data);
    end
    if (frame_err) ferr_cnt++;
    if (rx_valid && frame_err) both_cnt++;
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame: start, 8 data bits LSB first, stop bit at level stop_lvl.
  task automatic send_byte(input logic [7:0] b, input int bit_clks, input logic stop_lvl);
    rx = 1'b0;
    wait_clks(bit_clks);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(bit_clks);
    end
    rx = stop_lvl;
    wait_clks(bit_clks);
    rx = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx  = 1'b1;
    wait_clks(4);
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    wait_clks(2 * BIT_CLKS);
  endtask

  task automatic test_single_a5;
    int v0, f0, c0, lat;
    v0 = valid_cnt; f0 = ferr_cnt;
    c0 = cyc;
    fork
      send_byte(8'hA5, BIT_CLKS, 1'b1);
      begin
        wait_clks(BIT_CLKS * 3);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL a5_busy_mid: got %b want 1", busy); end
      end
    join
    wait_clks(2 * BIT_CLKS);
    lat = last_valid_cyc - c0;
    n_checks++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL a5_valid_count: got %0d want 1", valid_cnt - v0); end
    n_checks++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL a5_rx_data: got %h want a5", rx_data); end
    n_checks++; if (ferr_cnt - f0 !== 0) begin n_fail++; $display("FAIL a5_frame_err: got %0d pulses want 0", ferr_cnt - f0); end
    // 152 ticks * 10 clks + 2 synchroniser clks + at most 1 clk.
    n_checks++; if (lat < 1522 || lat > 1523) begin n_fail++; $display("FAIL a5_latency: got %0d clks want 1522..1523", lat); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL a5_busy_idle: got %b want 0", busy); end
  endtask

  task automatic test_glitch;
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    wait_clks(30);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_start: got %b want 1", busy); end
    wait_clks(20);
    rx = 1'b1;
    wait_clks(2 * BIT_CLKS);
    n_checks++; if (valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL glitch_valid: got %0d pulses want 0", valid_cnt - v0); end
    n_checks++; if (ferr_cnt - f0 !== 0) begin n_fail++; $display("FAIL glitch_frame_err: got %0d pulses want 0", ferr_cnt - f0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_idle: got %b want 0", busy); end
  endtask

  task automatic test_frame_err;
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    send_byte(8'h5A, BIT_CLKS, 1'b0);
    wait_clks(3 * BIT_CLKS);
    n_checks++; if (ferr_cnt - f0 !== 1) begin n_fail++; $display("FAIL ferr_count: got %0d pulses want 1", ferr_cnt - f0); end
    n_checks++; if (valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL ferr_valid: got %0d pulses want 0", valid_cnt - v0); end
    n_checks++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL ferr_rx_data_hold: got %h want a5", rx_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_busy_idle: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    int v0, f0, q0;
    logic [7:0] exp [3];
    exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'h3C;
    v0 = valid_cnt; f0 = ferr_cnt; q0 = data_q.size();
    for (int i = 0; i < 3; i++) send_byte(exp[i], BIT_CLKS, 1'b1);
    wait_clks(2 * BIT_CLKS);
    n_checks++; if (valid_cnt - v0 !== 3) begin n_fail++; $display("FAIL b2b_valid_count: got %0d want 3", valid_cnt - v0); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (data_q.size() <= q0 + i) begin
        n_fail++; $display("FAIL b2b_data%0d: got no word want %h", i, exp[i]);
      end else if (data_q[q0 + i] !== exp[i]) begin
        n_fail++; $display("FAIL b2b_data%0d: got %h want %h", i, data_q[q0 + i], exp[i]);
      end
    end
    n_checks++; if (ferr_cnt - f0 !== 0) begin n_fail++; $display("FAIL b2b_frame_err: got %0d pulses want 0", ferr_cnt - f0); end
  endtask

  task automatic test_reset_mid_frame;
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    // Start bit and bits 0..3 of 0x00, then halfway into bit 4.
    rx = 1'b0;
    wait_clks(5 * BIT_CLKS + BIT_CLKS / 2);
    rst = 1'b1;
    wait_clks(3);
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_rx_data: got %h want 00", rx_data); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_rx_valid: got %b want 0", rx_valid); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_frame_err: got %b want 0", frame_err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    rx = 1'b1;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(2 * BIT_CLKS);
    send_byte(8'h81, BIT_CLKS, 1'b1);
    wait_clks(2 * BIT_CLKS);
    n_checks++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL rstmid_valid_count: got %0d want 1", valid_cnt - v0); end
    n_checks++; if (rx_data !== 8'h81) begin n_fail++; $display("FAIL rstmid_rx_data_after: got %h want 81", rx_data); end
    n_checks++; if (ferr_cnt - f0 !== 0) begin n_fail++; $display("FAIL rstmid_frame_err_after: got %0d pulses want 0", ferr_cnt - f0); end
  endtask

  task automatic test_baud_tolerance;
    int periods [2];
    periods[0] = BIT_SLOW; periods[1] = BIT_FAST;
    for (int i = 0; i < 2; i++) begin
      int v0, f0;
      v0 = valid_cnt; f0 = ferr_cnt;
      send_byte(8'hC3, periods[i], 1'b1);
      wait_clks(2 * BIT_CLKS);
      n_checks++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL tol%0d_valid_count: got %0d want 1", periods[i], valid_cnt - v0); end
      n_checks++; if (rx_data !== 8'hC3) begin n_fail++; $display("FAIL tol%0d_rx_data: got %h want c3", periods[i], rx_data); end
      n_checks++; if (ferr_cnt - f0 !== 0) begin n_fail++; $display("FAIL tol%0d_frame_err: got %0d pulses want 0", periods[i], ferr_cnt - f0); end
    end
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_a5();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid_frame();
    test_baud_tolerance();
    n_checks++; if (both_cnt !== 0) begin n_fail++; $display("FAIL valid_and_ferr_overlap: got %0d cycles want 0", both_cnt); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver for the board-level serial link. It deserialises the RsRx line (8N1, LSB first) into bytes for the processor/display logic in `top`, and is the receive-side counterpart of the existing transmit path. It oversamples the line, validates the start bit, samples each bit at its midpoint, and flags bad stop bits.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, line baud rate.
- OVERSAMPLE, 16, sample ticks per bit period. Must be even and ≥ 4.
- DATA_BITS, 8, payload bits per frame.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- rx  input  1  serial line, idle high, asynchronous to clk.
- rx_data  output  DATA_BITS  last correctly framed byte.
- rx_valid  output  1  one-cycle pulse; rx_data is updated in the same cycle.
- frame_err  output  1  one-cycle pulse when the stop bit samples low.
- busy  output  1  high whenever state ≠ IDLE.

Behaviour:
- Reset value of all outputs:
  - rx_data = 0, rx_valid = 0, frame_err = 0, busy = 0.
  - State = IDLE; shift register, bit counter and tick counters all 0.
  - The synchroniser flops reset to 1 (idle level).
- Synchroniser: rx passes through 2 flops to give rx_s. The FSM uses only rx_s.
- Tick generator:
  - DIV = CLK_FREQ / (BAUD*OVERSAMPLE), integer-truncated; 651 with the defaults.
  - Counter runs 0..DIV-1 and emits a 1-cycle `tick` when it equals DIV-1.
  - The counter is cleared on the IDLE→START transition, so sampling phase is aligned to the detected start edge.
- FSM states: IDLE, START, DATA, STOP. A sample counter `sc` counts ticks within a bit.
  - IDLE: on rx_s == 0 → START, with sc = 0 and the tick counter cleared.
  - START: count ticks. When sc reaches OVERSAMPLE/2-1 on a tick (mid start bit):
    - rx_s == 0 → DATA, sc = 0, bit counter = 0.
    - rx_s == 1 → IDLE (glitch rejected; no output pulses).
  - DATA: on every tick with sc == OVERSAMPLE-1, sample rx_s into the shift register MSB, shift right (LSB-first assembly), set sc = 0 and increment the bit counter. After DATA_BITS samples → STOP.
  - STOP: on the tick with sc == OVERSAMPLE-1 (mid stop bit):
    - rx_s == 1 → rx_data <= shift register and rx_valid = 1 for exactly one clk.
    - rx_s == 0 → frame_err = 1 for one clk, and rx_data holds its previous value.
    - In both cases → IDLE in the same cycle.
- Timing:
  - Return to IDLE at mid stop bit means a following start edge is detected with no lost frames at full back-to-back rate.
  - Latency from the falling start edge to rx_valid: 2 synchroniser clks + (OVERSAMPLE/2 + DATA_BITS*OVERSAMPLE + OVERSAMPLE) ticks, i.e. 152 ticks with the defaults, plus at most 1 clk.
- Line held low (break): produces a frame_err pulse, then the FSM re-enters START at once because rx_s is still 0. A start is only accepted if the line is still low at mid-bit, so continuous low gives one frame_err per 9.5 bit times. This is acceptable.
- rx_valid and frame_err are never high in the same cycle.
- No back-pressure: the consumer must take rx_data within one frame time. rx_data is stable until the next valid frame.
- Reset asserted mid-frame: immediate return to reset values; no pulse is emitted. After release, the receiver waits for the next falling edge in IDLE.
- Tolerance: any baud error within ±3% between transmitter and receiver must decode correctly, given mid-bit sampling.

Decomposition:
- Shared package uart_pkg holds:
  - the `uart_rx_state_t` enum {IDLE, START, DATA, STOP};
  - the default constants CLK_FREQ_HZ and UART_BAUD;
  - a function computing DIV from the parameters.
- One sub-module, uart_baud_tick:
  - Parameters: DIV.
  - Ports: clk, rst, clr, tick.
  - Resets asynchronously to count 0 with tick 0.
- The synchroniser stays inline.

Test Plan:
All scenarios use CLK_FREQ=1_600_000, BAUD=10_000, OVERSAMPLE=16, which gives DIV=10.
- Send frame 0xA5 at nominal baud → one rx_valid pulse, rx_data=8'hA5, frame_err never high, busy low once back in IDLE.
- Send 0x00, 0xFF, 0x3C back-to-back with stop bits of exactly one bit and no idle gap → three rx_valid pulses with rx_data 00, FF, 3C in order; no frame_err.
- Pulse rx low for 5 ticks (50 clks), then high → FSM returns to IDLE at mid start bit; no rx_valid, no frame_err.
- Send 0x5A with the stop bit driven low → one frame_err pulse, rx_valid stays 0, rx_data keeps the prior value (0xA5 from the first scenario).
- Assert rst during bit 4 of a frame, release, then send 0x81 → all outputs are 0 during reset, no spurious pulse, then rx_data=8'h81 with one rx_valid.
- Send 0xC3 with the transmitter bit period at +3% and then −3% → rx_data=8'hC3 both times; no frame_err.
